// File: rtl/me_pkg.sv
// me_pkg: shared state type and size helpers for the motion search engine
package me_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, SEARCH, RESULT} state_t;
  function automatic int sad_w(input int pix_w, input int mb_w, input int mb_h);
    return pix_w + $clog2(mb_w * mb_h);
  endfunction
  function automatic int beats(input int mb_w, input int mb_h, input int lanes);
    return mb_w * mb_h / lanes;
  endfunction
  function automatic int ncand(input int sx, input int sy);
    return (2 * sx + 1) * (2 * sy + 1);
  endfunction
endpackage

// File: rtl/me_sad_tree.sv
// me_sad_tree: LANES-wide absolute-difference sum of two pixel beats
module me_sad_tree #(
  parameter int PIX_W = 8,
  parameter int LANES = 4,
  parameter int SAD_W = 16
) (
  input  logic [LANES*PIX_W-1:0] a,
  input  logic [LANES*PIX_W-1:0] b,
  output logic [SAD_W-1:0]       sad
);
  always_comb begin
    sad = '0;
    for (int i = 0; i < LANES; i++)
      sad = sad + SAD_W'(a[i*PIX_W +: PIX_W] > b[i*PIX_W +: PIX_W] ?
                         a[i*PIX_W +: PIX_W] - b[i*PIX_W +: PIX_W] :
                         b[i*PIX_W +: PIX_W] - a[i*PIX_W +: PIX_W]);
  end
endmodule

// File: rtl/motion_search_engine.sv
// motion_search_engine: full-search SAD block motion estimator with LANES-wide strided reference reads
module motion_search_engine
  import me_pkg::*;
#(
  parameter int MB_W   = 16,
  parameter int MB_H   = 16,
  parameter int PIX_W  = 8,
  parameter int LANES  = 4,
  parameter int SRCH_X = 8,
  parameter int SRCH_Y = 8,
  parameter int ADDR_W = 32,
  localparam int SAD_W = sad_w(PIX_W, MB_W, MB_H)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_valid,
  output logic                    start_ready,
  input  logic [ADDR_W-1:0]       ref_base_addr,
  input  logic [ADDR_W-1:0]       frame_stride,
  input  logic [SAD_W-1:0]        early_thr,
  input  logic                    cur_valid,
  output logic                    cur_ready,
  input  logic [LANES*PIX_W-1:0]  cur_data,
  output logic [ADDR_W-1:0]       ref_addr,
  output logic                    ref_rd,
  input  logic [LANES*PIX_W-1:0]  ref_data,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [15:0]      mv_x,
  output logic signed [15:0]      mv_y,
  output logic [SAD_W-1:0]        sad_min,
  output logic                    early_exit
);
  localparam int BEATS = beats(MB_W, MB_H, LANES);
  localparam int CG    = MB_W / LANES;
  localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
  state_t state_q, state_d;
  logic [LANES*PIX_W-1:0] cur_mem [BEATS];
  logic [BW-1:0] ld_cnt, iss_beat, beat_q;
  logic [15:0] iss_c, iss_r;
  logic signed [15:0] iss_dx, iss_dy, dx_q, dy_q;
  logic iss_done, rd_q;
  logic [ADDR_W-1:0] base_q, stride_q, addr_c;
  logic [SAD_W-1:0] thr_q, acc, beat_sad, cand_sad;
  logic accept, cur_fire, ld_last, issue, cmp, better, early, done;
  logic end_c, end_r, end_dx, end_dy;
  assign start_ready = state_q == IDLE;
  assign cur_ready   = state_q == LOAD;
  assign res_valid   = state_q == RESULT;
  assign accept      = start_valid && start_ready;
  assign cur_fire    = cur_valid && cur_ready;
  assign ld_last     = cur_fire && ld_cnt == BW'(BEATS - 1);
  assign issue       = state_q == SEARCH && !iss_done;
  assign end_c       = iss_c == 16'(CG - 1);
  assign end_r       = iss_r == 16'(MB_H - 1);
  assign end_dx      = iss_dx == 16'(SRCH_X);
  assign end_dy      = iss_dy == 16'(SRCH_Y);
  assign addr_c      = base_q + (ADDR_W'(iss_dy) + ADDR_W'(iss_r)) * stride_q
                     + ADDR_W'(iss_dx) + ADDR_W'(iss_c) * ADDR_W'(LANES);
  assign ref_rd      = issue;
  assign ref_addr    = issue ? addr_c : '0;
  me_sad_tree #(.PIX_W(PIX_W), .LANES(LANES), .SAD_W(SAD_W)) u_sad (
    .a(ref_data), .b(cur_mem[beat_q]), .sad(beat_sad)
  );
  // Data returns one cycle after issue, so the return side tracks delayed issue coordinates.
  assign cand_sad = (beat_q == '0 ? '0 : acc) + beat_sad;
  assign cmp      = state_q == SEARCH && rd_q && beat_q == BW'(BEATS - 1);
  assign better   = cmp && cand_sad < sad_min;
  assign early    = cmp && thr_q != '0 && cand_sad < thr_q;
  assign done     = cmp && (early || (dx_q == 16'(SRCH_X) && dy_q == 16'(SRCH_Y)));
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_valid ? LOAD : IDLE;
      LOAD:    state_d = ld_last ? SEARCH : LOAD;
      SEARCH:  state_d = done ? RESULT : SEARCH;
      RESULT:  state_d = res_ready ? IDLE : RESULT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rd_q       <= 1'b0;
      mv_x       <= '0;
      mv_y       <= '0;
      sad_min    <= '0;
      early_exit <= 1'b0;
    end else begin
      state_q <= state_d;
      rd_q    <= issue;
      if (accept) begin
        sad_min    <= '1;
        mv_x       <= '0;
        mv_y       <= '0;
        early_exit <= 1'b0;
      end
      if (better) begin
        sad_min <= cand_sad;
        mv_x    <= dx_q;
        mv_y    <= dy_q;
      end
      if (early) early_exit <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      base_q   <= ref_base_addr;
      stride_q <= frame_stride;
      thr_q    <= early_thr;
      ld_cnt   <= '0;
    end
    if (cur_fire) begin
      cur_mem[ld_cnt] <= cur_data;
      ld_cnt          <= ld_cnt + 1'b1;
    end
    if (ld_last) begin
      iss_c    <= '0;
      iss_r    <= '0;
      iss_beat <= '0;
      iss_dx   <= 16'(-SRCH_X);
      iss_dy   <= 16'(-SRCH_Y);
      iss_done <= 1'b0;
    end else if (issue) begin
      iss_c    <= end_c ? '0 : iss_c + 16'd1;
      iss_beat <= end_c && end_r ? '0 : iss_beat + 1'b1;
      if (end_c) iss_r <= end_r ? '0 : iss_r + 16'd1;
      if (end_c && end_r) iss_dx <= end_dx ? 16'(-SRCH_X) : iss_dx + 16'sd1;
      if (end_c && end_r && end_dx) iss_dy <= iss_dy + 16'sd1;
      if (end_c && end_r && end_dx) iss_done <= end_dy;
    end
    if (issue) begin
      beat_q <= iss_beat;
      dx_q   <= iss_dx;
      dy_q   <= iss_dy;
    end
    if (state_q == SEARCH && rd_q) acc <= cand_sad;
  end
endmodule

// File: tb/tb_motion_search_engine.sv
// tb_motion_search_engine: directed checks of load, search, tie rule, early exit, backpressure and reset abort
module tb_motion_search_engine;
  localparam int BASE = 1024;
  logic clk = 0, rst = 1, start_valid = 0, cur_valid = 0, res_ready = 0;
  logic [31:0] ref_base_addr = 32'(BASE), frame_stride = 32'd64;
  logic [11:0] early_thr = '0;
  logic [15:0] cur_data = '0, ref_data = '0;
  logic start_ready, cur_ready, ref_rd, res_valid, early_exit;
  logic [31:0] ref_addr;
  logic signed [15:0] mv_x, mv_y;
  logic [11:0] sad_min;
  logic [7:0] refm [0:4095];
  logic [7:0] cur [4][4];
  int vecs = 0, errs = 0;
  int lat, nrd;
  logic [31:0] a0;
  motion_search_engine #(.MB_W(4), .MB_H(4), .PIX_W(8), .LANES(2), .SRCH_X(2), .SRCH_Y(2), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .ref_base_addr(ref_base_addr), .frame_stride(frame_stride), .early_thr(early_thr),
    .cur_valid(cur_valid), .cur_ready(cur_ready), .cur_data(cur_data),
    .ref_addr(ref_addr), .ref_rd(ref_rd), .ref_data(ref_data),
    .res_valid(res_valid), .res_ready(res_ready), .mv_x(mv_x), .mv_y(mv_y),
    .sad_min(sad_min), .early_exit(early_exit)
  );
  always #5 clk = ~clk;
  always @(posedge clk) ref_data <= {refm[ref_addr[11:0] + 12'd1], refm[ref_addr[11:0]]};
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic fill(input bit rnd, input logic [7:0] rv, input logic [7:0] cv);
    for (int i = 0; i < 4096; i++) refm[i] = rnd ? 8'($urandom) : rv;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) cur[r][c] = rnd ? 8'($urandom) : cv;
  endtask
  task automatic copy_at(input int dx, input int dy);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) refm[BASE + (dy + r) * 64 + dx + c] = cur[r][c];
  endtask
  task automatic run(input logic [11:0] thr, input bit stall, input int abort);
    int n = 0, b = 0;
    nrd = 0;
    a0 = '0;
    @(negedge clk);
    start_valid = 1;
    early_thr = thr;
    while (n < 1000) begin
      @(negedge clk);
      n++;
      start_valid = 0;
      if (res_valid) break;
      if (ref_rd) begin
        if (nrd == 0) a0 = ref_addr;
        nrd++;
      end
      if (abort != 0 && n == abort) begin
        cur_valid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        return;
      end
      if (cur_ready && b < 8 && (!stall || n % 2 == 1)) begin
        cur_valid = 1;
        cur_data = {cur[b / 2][2 * (b % 2) + 1], cur[b / 2][2 * (b % 2)]};
        b++;
      end else cur_valid = 0;
    end
    cur_valid = 0;
    lat = n;
  endtask
  task automatic check_res(input string t, input int dx, input int dy, input int sad, input bit ee);
    chk({t, "_valid"}, 32'(res_valid), 1);
    chk({t, "_mvx"}, 32'($signed(mv_x)), 32'(dx));
    chk({t, "_mvy"}, 32'($signed(mv_y)), 32'(dy));
    chk({t, "_sad"}, 32'(sad_min), 32'(sad));
    chk({t, "_ee"}, 32'(early_exit), 32'(ee));
  endtask
  task automatic take();
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    chk("after_take_start_ready", 32'(start_ready), 1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("rst_start_ready", 32'(start_ready), 1);
    chk("rst_cur_ready", 32'(cur_ready), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_ref_rd", 32'(ref_rd), 0);
    chk("rst_ref_addr", ref_addr, 0);
    chk("rst_mv", {mv_x, mv_y}, 0);
    chk("rst_sad", 32'(sad_min), 0);
    chk("rst_ee", 32'(early_exit), 0);
    fill(1, 0, 0);
    copy_at(1, -2);
    run(0, 0, 0);
    check_res("t1", 1, -2, 0, 0);
    chk("t1_lat", lat, 210);
    chk("t1_reads", nrd, 200);
    chk("t1_addr0", a0, BASE - 130);
    take();
    fill(0, 8'h80, 8'h80);
    run(0, 0, 0);
    check_res("t2", -2, -2, 0, 0);
    take();
    fill(1, 0, 0);
    copy_at(0, 0);
    run(1, 0, 0);
    check_res("t3", 0, 0, 0, 1);
    chk("t3_reads", nrd, 105);
    chk("t3_rd_idle", 32'(ref_rd), 0);
    take();
    fill(0, 8'h00, 8'hFF);
    run(0, 0, 0);
    check_res("t4", -2, -2, 4080, 0);
    chk("t4_addr0", a0, BASE - 130);
    take();
    fill(1, 0, 0);
    copy_at(1, -2);
    run(0, 1, 0);
    check_res("t5", 1, -2, 0, 0);
    for (int i = 0; i < 10; i++) begin
      start_valid = i == 5;
      @(negedge clk);
      chk("t5_hold_valid", 32'(res_valid), 1);
      chk("t5_hold_mv", {mv_x, mv_y}, {16'sd1, -16'sd2});
      chk("t5_hold_sad", 32'(sad_min), 0);
      chk("t5_hold_start_ready", 32'(start_ready), 0);
      chk("t5_hold_cur_ready", 32'(cur_ready), 0);
    end
    start_valid = 0;
    take();
    run(0, 0, 40);
    chk("t6_ref_rd", 32'(ref_rd), 0);
    chk("t6_res_valid", 32'(res_valid), 0);
    chk("t6_start_ready", 32'(start_ready), 1);
    chk("t6_cur_ready", 32'(cur_ready), 0);
    run(0, 0, 0);
    check_res("t6", 1, -2, 0, 0);
    chk("t6_lat", lat, 210);
    chk("t6_reads", nrd, 200);
    take();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
